// File: rtl/bundle_counter_if.sv
// Bundle counter port group: one beat-valid input stream plus bundled results.
// store_flag is a valid with no ready: the counter accepts a beat every cycle it is high.
interface bundle_counter_if #(
  parameter int W       = 30,
  parameter int CORENUM = 32,
  parameter int LANES   = 4
);
  logic                       store_flag;
  logic [CORENUM-1:0]         store;
  logic [CORENUM*LANES-1:0]   core_result;
  logic                       clear;
  logic [LANES-1:0]           sign_bits;
  logic                       busy;
  logic [W-1:0]               beat_cnt;
  logic [LANES-1:0]           sat;

  modport master (
    output store_flag, store, core_result, clear,
    input  sign_bits, busy, beat_cnt, sat
  );

  modport slave (
    input  store_flag, store, core_result, clear,
    output sign_bits, busy, beat_cnt, sat
  );
endinterface

// File: rtl/bundle_counter.sv
// Multi-lane majority-vote accumulator for hypervector bundling (3-stage pipeline).
// Define BUNDLE_COUNTER_SAT_EN to clamp accumulators instead of wrapping.
module bundle_counter #(
  parameter int W       = 30,
  parameter int CORENUM = 32,
  parameter int LANES   = 4,
  parameter int TIE_ONE = 0
) (
  input  logic             clk,
  input  logic             rst,
  bundle_counter_if.slave  bus
);
  localparam int SW = $clog2(CORENUM + 1) + 1;

  if (W < SW + 1) begin : g_width_check
    $error("bundle_counter: W must be at least SW+1");
  end
  if (CORENUM < 1 || CORENUM > 64) begin : g_core_check
    $error("bundle_counter: CORENUM must be in 1..64");
  end

  localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]        CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic signed [1:0]    sel_q   [LANES][CORENUM];
  logic                 v1_q;
  logic signed [SW-1:0] sum_c   [LANES];
  logic signed [SW-1:0] sum_q   [LANES];
  logic                 v2_q;
  logic signed [W-1:0]  acc_q   [LANES];
  logic signed [W-1:0]  addend  [LANES];
  logic signed [W-1:0]  acc_nxt [LANES];
  logic [LANES-1:0]     ovf_c;
  logic [LANES-1:0]     sat_q;
  logic [W-1:0]         cnt_q;

  // S1: per-core, per-lane vote in {-1, 0, +1}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < CORENUM; k++)
          sel_q[l][k] <= 2'b00;
    end else begin
      v1_q <= bus.store_flag;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < CORENUM; k++)
          if (bus.store_flag && bus.store[k])
            sel_q[l][k] <= bus.core_result[k*LANES + l] ? 2'b01 : 2'b11;
          else
            sel_q[l][k] <= 2'b00;
    end
  end

  // S2: lane sums; SW bits hold +/-CORENUM, so no overflow here
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sum_c[l] = '0;
      for (int k = 0; k < CORENUM; k++)
        sum_c[l] = sum_c[l] + SW'(sel_q[l][k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q <= 1'b0;
      for (int l = 0; l < LANES; l++)
        sum_q[l] <= '0;
    end else begin
      v2_q <= v1_q;
      for (int l = 0; l < LANES; l++)
        sum_q[l] <= sum_c[l];
    end
  end

  // S3 next value: overflow is same-sign operands giving a different-sign result
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      addend[l]  = W'(sum_q[l]);
      acc_nxt[l] = acc_q[l] + addend[l];
      ovf_c[l]   = (acc_q[l][W-1] == addend[l][W-1]) &&
                   (acc_nxt[l][W-1] != acc_q[l][W-1]);
`ifdef BUNDLE_COUNTER_SAT_EN
      if (ovf_c[l])
        acc_nxt[l] = acc_q[l][W-1] ? ACC_MIN : ACC_MAX;
`endif
    end
  end

  // Clear only touches S3; beats still in S1/S2 land after it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sat_q <= '0;
      for (int l = 0; l < LANES; l++)
        acc_q[l] <= '0;
    end else if (bus.clear) begin
      sat_q <= '0;
      if (v2_q) begin
        cnt_q <= CNT_ONE;
        for (int l = 0; l < LANES; l++)
          acc_q[l] <= W'(sum_q[l]);
      end else begin
        cnt_q <= '0;
        for (int l = 0; l < LANES; l++)
          acc_q[l] <= '0;
      end
    end else if (v2_q) begin
      sat_q <= sat_q | ovf_c;
      if (cnt_q != '1)
        cnt_q <= cnt_q + CNT_ONE;
      for (int l = 0; l < LANES; l++)
        acc_q[l] <= acc_nxt[l];
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      if (acc_q[l][W-1])
        bus.sign_bits[l] = 1'b1;
      else if (acc_q[l] == '0)
        bus.sign_bits[l] = 1'(TIE_ONE);
      else
        bus.sign_bits[l] = 1'b0;
    end
  end

  assign bus.busy     = v1_q | v2_q | bus.store_flag;
  assign bus.beat_cnt = cnt_q;
  assign bus.sat      = sat_q;
endmodule

// File: tb/tb_bundle_counter.sv
// Self-checking bench for bundle_counter: directed steps plus random beats against a vote model.
module tb_bundle_counter;
  localparam int W   = 30;
  localparam int CN  = 32;
  localparam int L   = 4;
  localparam int TIE = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bundle_counter_if #(.W(W), .CORENUM(CN), .LANES(L)) bus ();
  bundle_counter_if #(.W(8), .CORENUM(CN), .LANES(L)) b8 ();

  bundle_counter #(.W(W), .CORENUM(CN), .LANES(L), .TIE_ONE(TIE)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  bundle_counter #(.W(8), .CORENUM(CN), .LANES(L), .TIE_ONE(TIE)) dut8 (
    .clk(clk), .rst(rst), .bus(b8));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic               v;
    logic [L-1:0][15:0] s;
  } beat_t;

  beat_t  pipe_q[$];
  longint m_acc [L];
  bit     m_sat [L];
  longint m_cnt;
  logic   cur_flag;

  localparam longint MAXV   = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINV   = -(64'sd1 <<< (W-1));
  localparam longint CNTMAX = (64'sd1 <<< W) - 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    beat_t z;
    z = '0;
    pipe_q.delete();
    pipe_q.push_back(z);
    pipe_q.push_back(z);
    for (int l = 0; l < L; l++) begin
      m_acc[l] = 0;
      m_sat[l] = 0;
    end
    m_cnt = 0;
  endtask

  // A beat sampled at edge e is accumulated at edge e+2; clear acts at that same point.
  task automatic model_edge(input logic f, input logic [CN-1:0] st,
                            input logic [CN*L-1:0] r, input logic c);
    beat_t  b, nb;
    longint t;
    int     s;
    b = pipe_q.pop_front();
    if (c) begin
      for (int l = 0; l < L; l++) begin
        m_acc[l] = b.v ? longint'($signed(b.s[l])) : 0;
        m_sat[l] = 0;
      end
      m_cnt = b.v ? 1 : 0;
    end else if (b.v) begin
      for (int l = 0; l < L; l++) begin
        t = m_acc[l] + longint'($signed(b.s[l]));
        if (t > MAXV || t < MINV) begin
          m_sat[l] = 1;
`ifdef BUNDLE_COUNTER_SAT_EN
          t = (t > MAXV) ? MAXV : MINV;
`else
          t = (t > MAXV) ? t - (64'sd1 <<< W) : t + (64'sd1 <<< W);
`endif
        end
        m_acc[l] = t;
      end
      if (m_cnt < CNTMAX) m_cnt++;
    end
    nb.v = f;
    for (int l = 0; l < L; l++) begin
      s = 0;
      if (f)
        for (int k = 0; k < CN; k++)
          if (st[k]) s += r[k*L + l] ? 1 : -1;
      nb.s[l] = 16'(s);
    end
    pipe_q.push_back(nb);
  endtask

  task automatic check_model();
    logic [L-1:0] es, esat;
    for (int l = 0; l < L; l++) begin
      es[l]   = (m_acc[l] < 0) ? 1'b1 : ((m_acc[l] > 0) ? 1'b0 : 1'(TIE));
      esat[l] = m_sat[l];
    end
    check("sign_bits", 64'(bus.sign_bits), 64'(es));
    check("beat_cnt",  64'(bus.beat_cnt),  64'(m_cnt));
    check("sat",       64'(bus.sat),       64'(esat));
    check("busy",      64'(bus.busy),      64'(pipe_q[0].v | pipe_q[1].v | cur_flag));
  endtask

  task automatic step(input logic f, input logic [CN-1:0] st,
                      input logic [CN*L-1:0] r, input logic c);
    bus.store_flag  = f;
    bus.store       = st;
    bus.core_result = r;
    bus.clear       = c;
    cur_flag        = f;
    @(posedge clk);
    model_edge(f, st, r, c);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [CN*L-1:0] mk_res(input logic [L-1:0][CN-1:0] lv);
    logic [CN*L-1:0] r;
    for (int k = 0; k < CN; k++)
      for (int l = 0; l < L; l++)
        r[k*L + l] = lv[l][k];
    return r;
  endfunction

  task automatic rand_step(input bit force_flag);
    logic f;
    f = force_flag ? 1'b1 : ($urandom_range(0, 3) != 0);
    step(f, $urandom, {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 15) == 0));
  endtask

  logic [L-1:0][CN-1:0] lv;

  initial begin
    bus.store_flag = 0; bus.store = '0; bus.core_result = '0; bus.clear = 0;
    b8.store_flag = 0;  b8.store = '0;  b8.core_result = '0;  b8.clear = 0;
    cur_flag = 0;
    model_reset();

    // Reset and idle
    #12;
    check("rst_sign", 64'(bus.sign_bits), 64'({L{1'(TIE)}}));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_cnt",  64'(bus.beat_cnt), 64'(0));
    check("rst_sat",  64'(bus.sat), 64'(0));
    check("rst8_cnt", 64'(b8.beat_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Single beat: lanes +32, -32, 0, +2
    lv[0] = '1; lv[1] = '0; lv[2] = 32'h0000_FFFF; lv[3] = 32'h0001_FFFF;
    step(1'b1, '1, mk_res(lv), 1'b0);
    idle(1);
    check("single_lat_cnt", 64'(bus.beat_cnt), 64'(0));
    idle(1);
    check("single_sign", 64'(bus.sign_bits), 64'(4'b0010));
    check("single_cnt",  64'(bus.beat_cnt), 64'(1));

    // Partial enable, then ignored beats with store_flag low
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 32'h0000_00FF, '0, 1'b0);
    idle(2);
    check("partial_sign", 64'(bus.sign_bits), 64'(4'b1111));
    for (int i = 0; i < 3; i++)
      step(1'b0, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    check("noflag_cnt", 64'(bus.beat_cnt), 64'(1));

    // Back-to-back beats of +32 on lane0
    step(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      lv[0] = '1; lv[1] = $urandom; lv[2] = $urandom; lv[3] = $urandom;
      step(1'b1, '1, mk_res(lv), 1'b0);
    end
    idle(1);
    check("b2b_busy_hold", 64'(bus.busy), 64'(1));
    idle(1);
    check("b2b_busy_drop", 64'(bus.busy), 64'(0));
    check("b2b_cnt", 64'(bus.beat_cnt), 64'(10));
    check("b2b_lane0", 64'(bus.sign_bits[0]), 64'(0));

    // Clear colliding with an in-flight beat of +5, followed by -3
    step(1'b1, 32'h0000_001F, '1, 1'b0);
    step(1'b1, 32'h0000_0007, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    check("coll_cnt",  64'(bus.beat_cnt), 64'(1));
    check("coll_sign", 64'(bus.sign_bits), 64'(4'b0000));
    idle(1);
    check("coll_next_cnt",  64'(bus.beat_cnt), 64'(2));
    check("coll_next_sign", 64'(bus.sign_bits), 64'(4'b0000));

    // Random traffic with occasional clears
    for (int i = 0; i < 300; i++) rand_step(1'b0);

    // Async reset in the middle of a stream
    for (int i = 0; i < 5; i++) rand_step(1'b1);
    #2;
    rst = 1'b0;
    bus.store_flag = 1'b0;
    cur_flag = 1'b0;
    #1;
    model_reset();
    check("arst_sign", 64'(bus.sign_bits), 64'({L{1'(TIE)}}));
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_cnt",  64'(bus.beat_cnt), 64'(0));
    check("arst_sat",  64'(bus.sat), 64'(0));
    #3;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) rand_step(1'b0);

    // Overflow on the 8-bit instance: 4 beats of +32 on lane0, -32 elsewhere
    lv[0] = '1; lv[1] = '0; lv[2] = '0; lv[3] = '0;
    b8.store = '1;
    b8.core_result = mk_res(lv);
    b8.store_flag = 1'b1;
    idle(4);
    b8.store_flag = 1'b0;
    idle(2);
    check("ovf_cnt", 64'(b8.beat_cnt), 64'(4));
    check("ovf_sat", 64'(b8.sat), 64'(4'b0001));
`ifdef BUNDLE_COUNTER_SAT_EN
    check("ovf_sign", 64'(b8.sign_bits), 64'(4'b1110));
`else
    check("ovf_sign", 64'(b8.sign_bits), 64'(4'b1111));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
